// File: rtl/xgriscv_dmem_resp_pkg.sv
// Shared encodings for the data-memory responder: access types and MMIO register offsets.
package xgriscv_dmem_resp_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  localparam logic [5:0] MMIO_CYCLE_LO = 6'h00;
  localparam logic [5:0] MMIO_CYCLE_HI = 6'h04;
  localparam logic [5:0] MMIO_TOHOST   = 6'h08;
  localparam logic [5:0] MMIO_ERR_STAT = 6'h0C;
  localparam logic [5:0] MMIO_ERR_ADDR = 6'h10;

  // Unlisted encodings behave as word accesses.
  function automatic logic dm_is_word(input logic [2:0] t);
    return !(t inside {DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U});
  endfunction

endpackage

// File: rtl/xgriscv_dmem_resp_lane_align.sv
// Combinational lane handling: store byte-enables/data replication, load extract/extend, misalign flag.
module dmem_lane_align
  import xgriscv_dmem_resp_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_type,
  input  logic [31:0] writedata,
  input  logic [31:0] rdword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? rdword[31:16] : rdword[15:0];
  assign byte_sel = rdword[{addr_lo, 3'b000} +: 8];

  always_comb begin
    byte_en   = '0;
    wdata_rep = writedata;
    load_data = '0;
    misalign  = 1'b0;
    case (dm_type)
      DM_HALF, DM_HALF_U: begin
        misalign  = addr_lo[0];
        wdata_rep = {2{writedata[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = (dm_type == DM_HALF) ? {{16{half_sel[15]}}, half_sel}
                                         : {16'h0000, half_sel};
      end
      DM_BYTE, DM_BYTE_U: begin
        wdata_rep = {4{writedata[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
        load_data = (dm_type == DM_BYTE) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h000000, byte_sel};
      end
      default: begin
        misalign  = |addr_lo;
        byte_en   = '1;
        load_data = rdword;
      end
    endcase
    // A misaligned access writes no lane and reads back zero.
    if (misalign) begin
      byte_en   = '0;
      load_data = '0;
    end
  end

endmodule

// File: rtl/xgriscv_dmem_resp.sv
// Data-memory responder for the single-cycle CPU: RAM, misalign capture and (with DMEM_MMIO_EN)
// an MMIO window holding the cycle counter, tohost mailbox and error registers.
module xgriscv_dmem_resp
  import xgriscv_dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic [2:0]  dm_type,
  output logic [31:0] readdata,
  output logic        tohost_done,
  output logic [31:0] tohost_value,
  output logic        err_misalign
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           rdword;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_rep;
  logic [31:0]           load_data;
  logic                  misalign;
  logic                  is_word;
  logic                  mmio_hit;
  logic                  mmio_ok;
  logic [31:0]           mmio_rdata;
  logic                  fault;
  logic                  err_clr;
  logic                  err_flag;
  logic                  unused_bits;

  assign idx     = addr[ADDR_WIDTH+1:2];
  assign rdword  = mem[idx];
  assign is_word = dm_is_word(dm_type);
  assign unused_bits = ^{addr[31:ADDR_WIDTH+2], MMIO_BASE};

  dmem_lane_align u_lane (
    .addr_lo   (addr[1:0]),
    .dm_type   (dm_type),
    .writedata (writedata),
    .rdword    (rdword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .load_data (load_data),
    .misalign  (misalign)
  );

`ifdef DMEM_MMIO_EN
  assign mmio_hit = (addr[31:6] == MMIO_BASE[31:6]);
`else
  assign mmio_hit = 1'b0;
`endif

  assign mmio_ok = mmio_hit && is_word && !misalign;
  // Sub-word MMIO accesses are silently dropped, so they never raise a misalign fault.
  assign fault   = (memread || memwrite) && misalign && (is_word || !mmio_hit);

  always_ff @(posedge clk) begin
    if (rstn && memwrite && !mmio_hit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    readdata = load_data;
    if (mmio_hit) readdata = mmio_ok ? mmio_rdata : '0;
  end

`ifdef DMEM_MMIO_EN
  logic [5:0]  off;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_shadow;
  logic [31:0] tohost_q;
  logic        tohost_done_q;
  logic        err_store;
  logic [31:0] err_addr;

  assign off     = addr[5:0];
  assign mmio_wr = memwrite && mmio_ok;
  assign mmio_rd = memread && mmio_ok;
  assign err_clr = mmio_wr && (off == MMIO_ERR_STAT) && writedata[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_cnt     <= '0;
      cycle_shadow  <= '0;
      tohost_q      <= '0;
      tohost_done_q <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      // Reading LO freezes HI so a LO-then-HI pair is coherent across a carry.
      if (mmio_rd && off == MMIO_CYCLE_LO) cycle_shadow <= cycle_cnt[63:32];
      if (mmio_wr && off == MMIO_TOHOST) begin
        tohost_q      <= writedata;
        tohost_done_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      MMIO_CYCLE_LO: mmio_rdata = cycle_cnt[31:0];
      MMIO_CYCLE_HI: mmio_rdata = cycle_shadow;
      MMIO_TOHOST:   mmio_rdata = tohost_q;
      MMIO_ERR_STAT: mmio_rdata = {30'h0, err_store, err_flag};
      MMIO_ERR_ADDR: mmio_rdata = err_addr;
      default:       mmio_rdata = '0;
    endcase
  end

  assign tohost_done  = tohost_done_q;
  assign tohost_value = tohost_q;
`else
  assign err_clr      = 1'b0;
  assign mmio_rdata   = '0;
  assign tohost_done  = 1'b0;
  assign tohost_value = '0;
`endif

  // A fault only records details when the flag is clear or being cleared on this edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_flag  <= 1'b0;
`ifdef DMEM_MMIO_EN
      err_store <= 1'b0;
      err_addr  <= '0;
`endif
    end else if (fault && (!err_flag || err_clr)) begin
      err_flag  <= 1'b1;
`ifdef DMEM_MMIO_EN
      err_store <= memwrite;
      err_addr  <= addr;
`endif
    end else if (err_clr) begin
      err_flag  <= 1'b0;
`ifdef DMEM_MMIO_EN
      err_store <= 1'b0;
`endif
    end
  end

  assign err_misalign = err_flag;

endmodule

// File: tb/tb_xgriscv_dmem_resp.sv
// Directed bench for xgriscv_dmem_resp: vector table plus misalign, MMIO and reset sequences.
module tb_xgriscv_dmem_resp;
  import xgriscv_dmem_resp_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        memwrite, memread;
  logic [31:0] addr, writedata;
  logic [2:0]  dm_type;
  logic [31:0] readdata;
  logic        tohost_done;
  logic [31:0] tohost_value;
  logic        err_misalign;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  dt;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  xgriscv_dmem_resp #(.ADDR_WIDTH(10), .MMIO_BASE(MB)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .memwrite     (memwrite),
    .memread      (memread),
    .addr         (addr),
    .writedata    (writedata),
    .dm_type      (dm_type),
    .readdata     (readdata),
    .tohost_done  (tohost_done),
    .tohost_value (tohost_value),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic [31:0] a,
                    input logic [31:0] wd, input logic [2:0] dt);
    memwrite  = w;
    memread   = r;
    addr      = a;
    writedata = wd;
    dm_type   = dt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read in the current cycle, compare mid-cycle, then advance past the edge.
  task automatic rd(input string nm, input logic [31:0] a, input logic [2:0] dt,
                    input logic [31:0] exp);
    op(1'b0, 1'b1, a, 32'h0, dt);
    #3;
    check(nm, readdata, exp);
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] dt);
    op(1'b1, 1'b0, a, wd, dt);
    step();
    op(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h10,   32'h8765_4321, DM_WORD,   1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h13,   32'h0,         DM_BYTE,   1'b1, 32'hFFFF_FF87};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,   32'h0,         DM_BYTE_U, 1'b1, 32'h0000_0087};
    vecs[3]  = '{1'b0, 1'b1, 32'h12,   32'h0,         DM_HALF,   1'b1, 32'hFFFF_8765};
    vecs[4]  = '{1'b0, 1'b1, 32'h12,   32'h0,         DM_HALF_U, 1'b1, 32'h0000_8765};
    vecs[5]  = '{1'b0, 1'b1, 32'h10,   32'h0,         DM_BYTE,   1'b1, 32'h0000_0021};
    vecs[6]  = '{1'b0, 1'b1, 32'h10,   32'h0,         DM_HALF,   1'b1, 32'h0000_4321};
    vecs[7]  = '{1'b1, 1'b0, 32'h20,   32'h0,         DM_WORD,   1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h21,   32'hFFFF_FFAB, DM_BYTE,   1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h22,   32'h5555_1234, DM_HALF,   1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h20,   32'h0,         DM_WORD,   1'b1, 32'h1234_AB00};
    vecs[11] = '{1'b0, 1'b1, 32'h10,   32'h0,         3'b111,    1'b1, 32'h8765_4321};
    vecs[12] = '{1'b0, 1'b1, 32'h1010, 32'h0,         DM_WORD,   1'b1, 32'h8765_4321};
    vecs[13] = '{1'b1, 1'b0, 32'h40,   32'hDEAD_BEEF, DM_WORD,   1'b0, 32'h0};

    rstn = 1'b0;
    op(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    check("rst_err_misalign", {31'h0, err_misalign}, 32'h0);
    check("rst_tohost_done", {31'h0, tohost_done}, 32'h0);
    check("rst_tohost_value", tohost_value, 32'h0);

    for (int i = 0; i < 14; i++) begin
      op(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].wd, vecs[i].dt);
      #3;
      if (vecs[i].chk) check($sformatf("vec%0d", i), readdata, vecs[i].exp);
      step();
    end
    op(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    check("aligned_no_err", {31'h0, err_misalign}, 32'h0);

    // Misaligned half store: suppressed and flagged
    wr(32'h41, 32'h0000_5A5A, DM_HALF);
    check("ms_err_set", {31'h0, err_misalign}, 32'h1);
    rd("ms_word_unchanged", 32'h40, DM_WORD, 32'hDEAD_BEEF);
    rd("ms_lw_zero", 32'h42, DM_WORD, 32'h0);
    rd("ms_lhu_zero", 32'h11, DM_HALF_U, 32'h0);

`ifdef DMEM_MMIO_EN
    rd("err_stat_3", MB + 32'h0C, DM_WORD, 32'h3);
    rd("err_addr_keep", MB + 32'h10, DM_WORD, 32'h41);
    wr(MB + 32'h0C, 32'h1, DM_WORD);
    check("w1c_flag", {31'h0, err_misalign}, 32'h0);
    rd("err_stat_clr", MB + 32'h0C, DM_WORD, 32'h0);
    wr(MB + 32'h0C, 32'h1, DM_WORD);
    rd("ms_lw6_zero", 32'h06, DM_WORD, 32'h0);
    rd("err_stat_load", MB + 32'h0C, DM_WORD, 32'h1);
    rd("err_addr_6", MB + 32'h10, DM_WORD, 32'h6);

    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    step();
    release dut.cycle_cnt;
    rd("cyc_lo_pre", MB, DM_WORD, 32'hFFFF_FFFF);
    rd("cyc_hi_pre", MB + 32'h04, DM_WORD, 32'h0);
    rd("cyc_lo_post", MB, DM_WORD, 32'h1);
    rd("cyc_hi_post", MB + 32'h04, DM_WORD, 32'h1);

    wr(MB + 32'h08, 32'h1, DM_WORD);
    check("tohost_done", {31'h0, tohost_done}, 32'h1);
    check("tohost_value", tohost_value, 32'h1);
    wr(MB + 32'h08, 32'h0000_00FF, DM_BYTE);
    check("tohost_sb_ignored", tohost_value, 32'h1);
    rd("tohost_rd", MB + 32'h08, DM_WORD, 32'h1);
    rd("mmio_half_rd", MB + 32'h08, DM_HALF, 32'h0);
    rd("mmio_hole_rd", MB + 32'h20, DM_WORD, 32'h0);
`else
    rd("ms_lw6_zero", 32'h06, DM_WORD, 32'h0);
    check("ms_err_sticky", {31'h0, err_misalign}, 32'h1);
`endif

    // One-cycle reset with a store in flight
    op(1'b1, 1'b0, 32'h10, 32'h5555_5555, DM_WORD);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    op(1'b0, 1'b0, 32'h0, 32'h0, DM_WORD);
    check("mid_rst_err", {31'h0, err_misalign}, 32'h0);
    check("mid_rst_done", {31'h0, tohost_done}, 32'h0);
    check("mid_rst_value", tohost_value, 32'h0);
    rd("mid_rst_store_dropped", 32'h10, DM_WORD, 32'h8765_4321);
    rd("mid_rst_ram_kept", 32'h20, DM_WORD, 32'h1234_AB00);
`ifdef DMEM_MMIO_EN
    rd("mid_rst_err_stat", MB + 32'h0C, DM_WORD, 32'h0);
    rd("mid_rst_err_addr", MB + 32'h10, DM_WORD, 32'h0);
    rd("mid_rst_tohost", MB + 32'h08, DM_WORD, 32'h0);
    rd("mid_rst_cyc_hi", MB + 32'h04, DM_WORD, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
